// File: rtl/mlp_infer_ctrl.sv
// Top-level sequencer for the two-layer MLP inference datapath: frame handshake,
// per-layer start/done sequencing with watchdog, one-deep result register, frame count.
module mlp_infer_ctrl #(
   parameter int OUTPUT_SIZE    = 10,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   in_load,
   output logic                   hid_start,
   input  logic                   hid_done,
   output logic                   out_start,
   input  logic                   out_done,
   input  logic [3:0]             class_idx_in,
   input  logic [OUTPUT_SIZE-1:0] onehot_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [3:0]             res_class,
   output logic [OUTPUT_SIZE-1:0] res_onehot,
   output logic                   busy,
   output logic                   timeout_err,
   input  logic                   err_clr,
   output logic [CNT_W-1:0]       frame_cnt
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HID_START,
      HID_WAIT,
      OUT_START,
      OUT_WAIT,
      SETTLE,
      CAPTURE
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wdog;
   logic            capture;
   logic            pop;
   logic            wd_expire;

   assign in_ready = (state == IDLE) && !timeout_err;
   assign in_load  = in_valid && in_ready;
   assign capture  = (state == CAPTURE) && (!res_valid || res_ready);
   assign pop      = res_valid && res_ready;

   // A done arriving on the final watchdog cycle wins over expiry.
   always_comb begin
      wd_expire = 1'b0;
      if (wdog == WD_LAST) begin
         if (state == HID_WAIT && !hid_done)
            wd_expire = 1'b1;
         if (state == OUT_WAIT && !out_done)
            wd_expire = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wdog        <= '0;
         hid_start   <= 1'b0;
         out_start   <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_class   <= '0;
         res_onehot  <= '0;
         timeout_err <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         hid_start <= 1'b0;
         out_start <= 1'b0;

         case (state)
            IDLE: begin
               if (in_load) begin
                  state     <= HID_START;
                  hid_start <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            HID_START: begin
               state <= HID_WAIT;
               wdog  <= '0;
            end
            HID_WAIT: begin
               if (hid_done) begin
                  state     <= OUT_START;
                  out_start <= 1'b1;
               end else if (wd_expire) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            OUT_START: begin
               state <= OUT_WAIT;
               wdog  <= '0;
            end
            OUT_WAIT: begin
               if (out_done) begin
                  state <= SETTLE;
               end else if (wd_expire) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            SETTLE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               if (capture) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (err_clr)
            timeout_err <= 1'b0;
         else if (wd_expire)
            timeout_err <= 1'b1;

         // Capture and pop on the same edge leaves the slot full with new data.
         if (capture) begin
            res_valid  <= 1'b1;
            res_class  <= class_idx_in;
            res_onehot <= onehot_in;
            frame_cnt  <= frame_cnt + 1'b1;
         end else if (pop) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_mlp_infer_ctrl;

   localparam int OS  = 10;
   localparam int TO  = 24;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_load;
   logic          hid_start, hid_done, out_start, out_done;
   logic [3:0]    class_idx_in;
   logic [OS-1:0] onehot_in;
   logic          res_valid, res_ready;
   logic [3:0]    res_class;
   logic [OS-1:0] res_onehot;
   logic          busy, timeout_err, err_clr;
   logic [CW-1:0] frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   mlp_infer_ctrl #(
      .OUTPUT_SIZE(OS),
      .TIMEOUT_CYCLES(TO),
      .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
      .hid_start(hid_start), .hid_done(hid_done),
      .out_start(out_start), .out_done(out_done),
      .class_idx_in(class_idx_in), .onehot_in(onehot_in),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_class(res_class), .res_onehot(res_onehot),
      .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 hidden pulse, 2 hidden wait, 3 output pulse,
   // 4 output wait, 5 settle, 6 waiting for a free result slot.
   int            m_phase, m_waited, m_cnt;
   bit            m_err, m_full;
   logic [3:0]    m_cls;
   logic [OS-1:0] m_oh;
   bit            m_take, m_give, m_expire, m_done_now;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_waited = 0; m_cnt = 0;
         m_err = 0; m_full = 0; m_cls = '0; m_oh = '0;
      end else begin
         m_take   = (m_phase == 6) && (!m_full || res_ready);
         m_give   = m_full && res_ready;
         m_expire = 0;
         case (m_phase)
            0: if (in_valid && !m_err) m_phase = 1;
            1, 3: begin m_phase = m_phase + 1; m_waited = 0; end
            2, 4: begin
               m_done_now = (m_phase == 2) ? hid_done : out_done;
               if (m_done_now) m_phase = m_phase + 1;
               else begin
                  m_waited = m_waited + 1;
                  if (m_waited == TO) begin m_expire = 1; m_phase = 0; end
               end
            end
            5: m_phase = 6;
            6: if (m_take) m_phase = 0;
            default: m_phase = 0;
         endcase
         if (err_clr) m_err = 0;
         else if (m_expire) m_err = 1;
         if (m_take) begin
            m_full = 1; m_cls = class_idx_in; m_oh = onehot_in;
            m_cnt = (m_cnt + 1) % (1 << CW);
         end else if (m_give) m_full = 0;
      end
   end

   always @(negedge clk) begin
      bit e_rdy;
      e_rdy = (m_phase == 0) && !m_err;
      chk("m_in_ready",    in_ready,    e_rdy);
      chk("m_in_load",     in_load,     in_valid && e_rdy);
      chk("m_hid_start",   hid_start,   m_phase == 1);
      chk("m_out_start",   out_start,   m_phase == 3);
      chk("m_busy",        busy,        m_phase != 0);
      chk("m_timeout_err", timeout_err, m_err);
      chk("m_res_valid",   res_valid,   m_full);
      chk("m_res_class",   res_class,   m_cls);
      chk("m_res_onehot",  res_onehot,  m_oh);
      chk("m_frame_cnt",   frame_cnt,   m_cnt);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 0; hid_done = 0; out_done = 0; res_ready = 0; err_clr = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic run_frame(input int hd, input int od, input logic [3:0] cls,
                            input logic [OS-1:0] oh);
      int k = 0;
      while (!in_ready && k < 200) begin tick(); k++; end
      if (k >= 200) chk("in_ready_wait", 0, 1);
      in_valid = 1; tick(); in_valid = 0;
      repeat (hd) tick();
      hid_done = 1; tick(); hid_done = 0;
      repeat (od) tick();
      out_done = 1; class_idx_in = cls; onehot_in = oh; tick(); out_done = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      class_idx_in = '0; onehot_in = '0;
      rst = 1'b1;
      in_valid = 0; hid_done = 0; out_done = 0; res_ready = 0; err_clr = 0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_in_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      tick();

      // Nominal frame
      in_valid = 1; #1;
      chk("nom_in_load", in_load, 1);
      tick(); in_valid = 0;
      chk("nom_hid_start", hid_start, 1);
      chk("nom_in_ready_busy", in_ready, 0);
      tick();
      chk("nom_hid_start_once", hid_start, 0);
      repeat (18) tick();
      hid_done = 1; tick(); hid_done = 0;
      chk("nom_out_start", out_start, 1);
      tick();
      chk("nom_out_start_once", out_start, 0);
      repeat (14) tick();
      out_done = 1; class_idx_in = 4'd7; onehot_in = 10'b0010000000;
      tick(); out_done = 0;
      chk("nom_rv_e1", res_valid, 0);
      tick();
      chk("nom_rv_e2", res_valid, 0);
      tick();
      chk("nom_rv_e3", res_valid, 1);
      chk("nom_class", res_class, 7);
      chk("nom_onehot", res_onehot, 10'b0010000000);
      chk("nom_cnt", frame_cnt, 1);
      res_ready = 1; tick(); res_ready = 0;
      chk("nom_pop", res_valid, 0);

      // Back-pressure
      do_reset();
      run_frame(5, 5, 4'd3, 10'b0000001000);
      tick(); tick();
      chk("bp_first", res_valid, 1);
      run_frame(5, 5, 4'd9, 10'b1000000000);
      repeat (3) tick();
      chk("bp_stall_busy", busy, 1);
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_hold_class", res_class, 3);
      res_ready = 1; tick();
      chk("bp_rv_stays", res_valid, 1);
      chk("bp_new_class", res_class, 9);
      chk("bp_cnt", frame_cnt, 2);
      tick(); res_ready = 0;
      chk("bp_drained", res_valid, 0);

      // Timeout on hidden layer
      do_reset();
      in_valid = 1; tick(); in_valid = 0;
      repeat (TO) tick();
      chk("to_before_err", timeout_err, 0);
      chk("to_before_busy", busy, 1);
      tick();
      chk("to_err", timeout_err, 1);
      chk("to_idle", busy, 0);
      chk("to_in_ready", in_ready, 0);
      in_valid = 1; #1;
      chk("to_no_load", in_load, 0);
      tick(); in_valid = 0;
      chk("to_stays_idle", busy, 0);
      err_clr = 1; tick(); err_clr = 0;
      chk("to_cleared", timeout_err, 0);
      chk("to_ready_again", in_ready, 1);

      // Done on the expiry cycle
      in_valid = 1; tick(); in_valid = 0;
      repeat (TO) tick();
      hid_done = 1; tick(); hid_done = 0;
      chk("col_out_start", out_start, 1);
      chk("col_no_err", timeout_err, 0);
      repeat (3) tick();
      out_done = 1; class_idx_in = 4'd2; onehot_in = 10'b0000000100;
      tick(); out_done = 0;
      tick(); tick();
      chk("col_result", res_valid, 1);
      res_ready = 1; tick(); res_ready = 0;

      // Spurious dones
      hid_done = 1; out_done = 1; tick(); hid_done = 0; out_done = 0;
      chk("sp_idle_busy", busy, 0);
      chk("sp_idle_hs", hid_start, 0);
      chk("sp_idle_os", out_start, 0);
      in_valid = 1; tick(); in_valid = 0;
      tick(); tick();
      hid_done = 1; tick(); hid_done = 0;
      tick(); tick();
      hid_done = 1; tick(); hid_done = 0;
      chk("sp_ow_no_start", out_start, 0);
      repeat (2) tick();
      chk("sp_ow_busy", busy, 1);
      out_done = 1; tick(); out_done = 0;
      tick(); tick();
      chk("sp_ow_result", res_valid, 1);

      // Asynchronous reset in OUT_WAIT (previous result left unpopped)
      in_valid = 1; tick(); in_valid = 0;
      tick(); hid_done = 1; tick(); hid_done = 0;
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_res_valid", res_valid, 0);
      chk("ar_frame_cnt", frame_cnt, 0);
      chk("ar_hid_start", hid_start, 0);
      chk("ar_out_start", out_start, 0);
      chk("ar_res_class", res_class, 0);
      tick(); rst = 1'b0; tick();
      res_ready = 1;
      run_frame(3, 3, 4'd5, 10'b0000100000);
      tick(); tick();
      chk("ar_after_cnt", frame_cnt, 1);
      chk("ar_after_class", res_class, 5);

      // Counter wrap at 2 bits
      for (int f = 0; f < 3; f++) begin
         run_frame(2 + f, 4, 4'(f), 10'(1 << f));
         tick(); tick();
      end
      chk("wrap_cnt", frame_cnt, 0);
      res_ready = 0;

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         hid_done     = ($urandom_range(0, 7) == 0);
         out_done     = ($urandom_range(0, 7) == 0);
         res_ready    = ($urandom_range(0, 1) == 1);
         err_clr      = ($urandom_range(0, 15) == 0);
         class_idx_in = 4'($urandom_range(0, 15));
         onehot_in    = 10'(1 << $urandom_range(0, 9));
         tick();
      end
      in_valid = 0; hid_done = 0; out_done = 0; err_clr = 0; res_ready = 0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
